// File: rtl/shift_pkg.sv
// Shared state encoding and step sizes for the iterative left shifter.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int STEP_BIG   = 8;
  localparam int STEP_SMALL = 1;

endpackage

// File: rtl/lsl_step.sv
// One combinational left step: by STEP_BIG or STEP_SMALL bits, with wrap-around or zero fill.
module lsl_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d,
  input  logic             big,
  input  logic             rot,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sh_big;
  logic [WIDTH-1:0] sh_small;
  logic [WIDTH-1:0] wrap_big;
  logic [WIDTH-1:0] wrap_small;

  assign sh_big     = d << STEP_BIG;
  assign sh_small   = d << STEP_SMALL;
  // Bits pushed past the MSB reappear at the LSB end only when rotating.
  assign wrap_big   = rot ? (d >> (WIDTH - STEP_BIG))   : '0;
  assign wrap_small = rot ? (d >> (WIDTH - STEP_SMALL)) : '0;

  assign q = big ? (sh_big | wrap_big) : (sh_small | wrap_small);

endmodule

// File: rtl/lshift_iter.sv
// Multi-cycle logical/rotate left shifter: consumes the amount 8 bits at a time, then 1 bit at a time.
module lshift_iter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   shamt,
  input  logic             rotate,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   rem;
  logic             rot;
  logic             big;
  logic [WIDTH-1:0] step_q;
  logic [SHW-1:0]   rem_nxt;

  assign big     = (rem >= SHW'(STEP_BIG));
  assign rem_nxt = big ? (rem - SHW'(STEP_BIG)) : (rem - SHW'(STEP_SMALL));

  lsl_step #(.WIDTH(WIDTH)) u_step (
    .d   (acc),
    .big (big),
    .rot (rot),
    .q   (step_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      rem    <= '0;
      acc    <= '0;
      rot    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            acc  <= a;
            rem  <= shamt;
            rot  <= rotate;
            busy <= 1'b1;
            if (shamt == '0) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              result <= a;
            end else begin
              state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          acc <= step_q;
          rem <= rem_nxt;
          // result is loaded from the final step's output so it is valid with done.
          if (rem_nxt == '0) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            result <= step_q;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
